// File: rtl/mem_i2c_slave.sv
// Memory-mapped I2C target: register file on a valid/ready bus, byte-wide RX/TX holding registers,
// synchronized and glitch-filtered SCL/SDA, open-drain SDA and no clock stretching.
//   state     | meaning
//   IDLE      | not part of a transaction
//   ADDR      | shifting in the address byte
//   ADDR_ACK  | driving ACK for our address
//   RX_BYTE   | shifting in a data byte from the master
//   RX_ACK    | driving ACK/NACK for the received byte
//   TX_BYTE   | shifting out a data byte
//   TX_ACK    | sampling the master's ACK/NACK
//   WAIT_STOP | bus busy for someone else, or master finished reading
module mem_i2c_slave #(
    parameter int FILTER_LEN = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_s_valid,
    input  logic [31:0] mem_s_addr,
    input  logic [31:0] mem_s_wdata,
    input  logic [3:0]  mem_s_wstrb,
    output logic        mem_s_ready,
    output logic [31:0] mem_s_rdata,
    inout  wire         scl,
    inout  wire         sda
);
    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP
    } state_t;

    // Index 0 is SCL, index 1 is SDA.
    logic [1:0]    s1_q, s2_q, f_q, p_q;
    logic [CW-1:0] cnt_q [2];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_q <= '1;
            s2_q <= '1;
            f_q  <= '1;
            p_q  <= '1;
            for (int i = 0; i < 2; i++) cnt_q[i] <= CW'(FILTER_LEN - 1);
        end else begin
            s1_q <= {sda, scl};
            s2_q <= s1_q;
            p_q  <= f_q;
            for (int i = 0; i < 2; i++) begin
                if (s2_q[i] == f_q[i]) begin
                    cnt_q[i] <= CW'(FILTER_LEN - 1);
                end else if (cnt_q[i] == '0) begin
                    f_q[i]   <= s2_q[i];
                    cnt_q[i] <= CW'(FILTER_LEN - 1);
                end else begin
                    cnt_q[i] <= cnt_q[i] - 1'b1;
                end
            end
        end
    end

    logic scl_rise, scl_fall, start_c, stop_c, sda_f;
    assign sda_f    = f_q[1];
    assign scl_rise = f_q[0] & ~p_q[0];
    assign scl_fall = ~f_q[0] & p_q[0];
    assign start_c  = f_q[0] & p_q[0] & p_q[1] & ~f_q[1];
    assign stop_c   = f_q[0] & p_q[0] & ~p_q[1] & f_q[1];

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d, ctrl_q, ctrl_d, txdata_q, txdata_d, rxdata_q, rxdata_d, rdata_q, rdata_d;
    logic       sda_drv_q, sda_drv_d, ph_q, ph_d, ack_q, ack_d;
    logic       tx_full_q, tx_full_d, rx_valid_q, rx_valid_d, addressed_q, addressed_d;
    logic       dir_q, dir_d, err_q, err_d, mnack_q, mnack_d, ready_q, ready_d, busy_q, busy_d;

    logic       acc, wr, rd, load_tx;
    logic [2:0] idx;
    logic [7:0] status, rd_mux, byte_in;
    logic       unused_bits;

    assign unused_bits = ^{mem_s_addr[31:5], mem_s_addr[1:0], mem_s_wdata[31:8]};
    assign acc     = mem_s_valid & ~busy_q;
    assign wr      = acc & (|mem_s_wstrb);
    assign rd      = acc & ~(|mem_s_wstrb);
    assign idx     = mem_s_addr[4:2];
    assign status  = {2'b00, mnack_q, err_q, dir_q, addressed_q, tx_full_q, rx_valid_q};
    assign byte_in = {shift_q[6:0], sda_f};

    always_comb begin
        case (idx)
            3'd0:    rd_mux = ctrl_q;
            3'd2:    rd_mux = rxdata_q;
            3'd3:    rd_mux = status;
            default: rd_mux = 8'h00;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        sda_drv_d   = sda_drv_q;
        ph_d        = ph_q;
        ack_d       = ack_q;
        ctrl_d      = ctrl_q;
        txdata_d    = txdata_q;
        tx_full_d   = tx_full_q;
        rxdata_d    = rxdata_q;
        rx_valid_d  = rx_valid_q;
        addressed_d = addressed_q;
        dir_d       = dir_q;
        err_d       = err_q;
        mnack_d     = mnack_q;
        busy_d      = mem_s_valid;
        ready_d     = acc;
        rdata_d     = rd ? rd_mux : 8'h00;
        load_tx     = 1'b0;

        // Bus-side clears come first so that protocol-side sets win.
        if (wr && idx == 3'd0) ctrl_d = mem_s_wdata[7:0];
        if (wr && idx == 3'd3) begin
            if (mem_s_wdata[4]) err_d = 1'b0;
            if (mem_s_wdata[5]) mnack_d = 1'b0;
        end
        if (rd && idx == 3'd2) rx_valid_d = 1'b0;

        case (state_q)
            ADDR: if (scl_rise) begin
                shift_d   = byte_in;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    ph_d = 1'b0;
                    if (byte_in[7:1] == ctrl_q[7:1]) begin
                        state_d     = ADDR_ACK;
                        addressed_d = 1'b1;
                        dir_d       = byte_in[0];
                    end else begin
                        state_d = WAIT_STOP;
                    end
                end
            end
            ADDR_ACK: begin
                if (scl_rise) ph_d = 1'b1;
                if (scl_fall) begin
                    if (!ph_q) begin
                        sda_drv_d = 1'b1;
                    end else begin
                        sda_drv_d = 1'b0;
                        bit_cnt_d = 3'd0;
                        ph_d      = 1'b0;
                        load_tx   = dir_q;
                        state_d   = dir_q ? TX_BYTE : RX_BYTE;
                    end
                end
            end
            RX_BYTE: if (scl_rise) begin
                shift_d   = byte_in;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    state_d = RX_ACK;
                    ph_d    = 1'b0;
                    if (!rx_valid_q) begin
                        rxdata_d   = byte_in;
                        rx_valid_d = 1'b1;
                        ack_d      = 1'b1;
                    end else begin
                        err_d = 1'b1;
                        ack_d = 1'b0;
                    end
                end
            end
            RX_ACK: begin
                if (scl_rise) ph_d = 1'b1;
                if (scl_fall) begin
                    if (!ph_q) begin
                        sda_drv_d = ack_q;
                    end else begin
                        sda_drv_d = 1'b0;
                        bit_cnt_d = 3'd0;
                        ph_d      = 1'b0;
                        state_d   = RX_BYTE;
                    end
                end
            end
            TX_BYTE: begin
                if (scl_rise) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = TX_ACK;
                        ph_d    = 1'b0;
                    end
                end
                if (scl_fall) begin
                    shift_d   = shift_q << 1;
                    sda_drv_d = ~shift_q[6];
                end
            end
            TX_ACK: begin
                if (scl_fall && !ph_q) sda_drv_d = 1'b0;
                if (scl_rise) begin
                    if (sda_f) begin
                        mnack_d = 1'b1;
                        state_d = WAIT_STOP;
                    end else begin
                        ph_d = 1'b1;
                    end
                end
                if (scl_fall && ph_q) begin
                    load_tx   = 1'b1;
                    bit_cnt_d = 3'd0;
                    ph_d      = 1'b0;
                    state_d   = TX_BYTE;
                end
            end
            default: ;
        endcase

        // An empty holding register sends 0xFF (SDA stays released) and flags the underrun.
        if (load_tx) begin
            if (tx_full_q) begin
                shift_d   = txdata_q;
                tx_full_d = 1'b0;
                sda_drv_d = ~txdata_q[7];
            end else begin
                shift_d   = 8'hFF;
                err_d     = 1'b1;
                sda_drv_d = 1'b0;
            end
        end

        if (stop_c) begin
            state_d     = IDLE;
            sda_drv_d   = 1'b0;
            addressed_d = 1'b0;
        end
        if (start_c && ctrl_q[0]) begin
            state_d   = ADDR;
            bit_cnt_d = 3'd0;
            sda_drv_d = 1'b0;
            ph_d      = 1'b0;
        end
        if (!ctrl_q[0]) begin
            state_d   = IDLE;
            sda_drv_d = 1'b0;
        end

        if (wr && idx == 3'd1) begin
            txdata_d  = mem_s_wdata[7:0];
            tx_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            sda_drv_q   <= 1'b0;
            ph_q        <= 1'b0;
            ack_q       <= 1'b0;
            ctrl_q      <= 8'h00;
            txdata_q    <= 8'h00;
            tx_full_q   <= 1'b0;
            rxdata_q    <= 8'h00;
            rx_valid_q  <= 1'b0;
            addressed_q <= 1'b0;
            dir_q       <= 1'b0;
            err_q       <= 1'b0;
            mnack_q     <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            rdata_q     <= 8'h00;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            sda_drv_q   <= sda_drv_d;
            ph_q        <= ph_d;
            ack_q       <= ack_d;
            ctrl_q      <= ctrl_d;
            txdata_q    <= txdata_d;
            tx_full_q   <= tx_full_d;
            rxdata_q    <= rxdata_d;
            rx_valid_q  <= rx_valid_d;
            addressed_q <= addressed_d;
            dir_q       <= dir_d;
            err_q       <= err_d;
            mnack_q     <= mnack_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            rdata_q     <= rdata_d;
        end
    end

    assign mem_s_ready = ready_q;
    assign mem_s_rdata = {24'd0, rdata_q};
    assign sda         = sda_drv_q ? 1'b0 : 1'bz;
    assign scl         = 1'bz;

endmodule

// File: doc/mem_i2c_slave.md
MEM_I2C_SLAVE -- requirements
Module: mem_i2c_slave

Interface
REQ-001 Parameter FILTER_LEN, default 3: number of consecutive identical clk samples required before a synchronized SCL or SDA level change is accepted.
REQ-002 clk  input  1  single system clock; all logic is clocked on its rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 mem_s_valid  input  1  bus request; held high by the master until mem_s_ready.
REQ-005 mem_s_addr  input  32  byte address; only [4:2] decoded as register index.
REQ-006 mem_s_wdata  input  32  write data; only [7:0] used.
REQ-007 mem_s_wstrb  input  4  nonzero = write, zero = read.
REQ-008 mem_s_ready  output  1  one-cycle access-complete pulse.
REQ-009 mem_s_rdata  output  32  read data, {24'd0, byte}, valid while mem_s_ready is high.
REQ-010 scl  inout  1  I2C clock; input only, never driven (no clock stretching).
REQ-011 sda  inout  1  I2C data; open-drain: driven 0 or released to 'z', never driven 1.

Function
REQ-012 Register map (index = addr[4:2]):
- 0 CTRL RW: bit0 EN, bits7:1 OWN_ADDR.
- 1 TXDATA W: load tx holding register; sets TX_FULL.
- 2 RXDATA R: return rx holding register; clears RX_VALID.
- 3 STATUS R/W1C: bit0 RX_VALID, bit1 TX_FULL, bit2 ADDRESSED, bit3 DIR (1 = master read), bit4 ERR (W1C), bit5 MNACK (W1C).
- Indices 4-7: reads return 0, writes are ignored.
REQ-013 Bus handshake:
- mem_s_ready is high exactly one cycle, in the cycle after the first cycle of mem_s_valid.
- Each access has exactly one side effect, regardless of how long valid is held.
- mem_s_valid must drop for at least one cycle before the next access.
REQ-014 Input conditioning: SCL and SDA pass through a 2-flop synchronizer, then the FILTER_LEN glitch filter; all protocol decisions use the filtered signals.
REQ-015 START = filtered SDA falling while filtered SCL is high. STOP = filtered SDA rising while filtered SCL is high.
REQ-016 Protocol FSM states: IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP.
REQ-017 START from any state (including a repeated START) when EN=1: clear the bit counter, go to ADDR, release sda.
REQ-018 STOP from any state: go to IDLE, release sda, clear ADDRESSED.
REQ-019 Bit timing: sda is sampled on the filtered SCL rising edge; sda drive changes only on the filtered SCL falling edge; bytes are transferred MSB first.
REQ-020 ADDR: after 8 bits, if [7:1] equals OWN_ADDR, go to ADDR_ACK, set ADDRESSED, and latch DIR = bit0. On mismatch, go to WAIT_STOP and never drive sda.
REQ-021 ADDR_ACK: drive sda low for the 9th SCL period. Then:
- DIR=0: go to RX_BYTE.
- DIR=1: load the tx shift register from TXDATA if TX_FULL (then clear TX_FULL); otherwise load 8'hFF and set ERR. Go to TX_BYTE.
REQ-022 RX_BYTE: after 8 bits, if RX_VALID=0, copy the byte to the rx holding register, set RX_VALID, and ACK. If RX_VALID=1, discard the byte, set ERR, and NACK (release sda). Either way, go to RX_ACK, then back to RX_BYTE.
REQ-023 TX_BYTE: shift out 8 bits, then release sda for TX_ACK. In TX_ACK, sample the master's bit:
- ACK (0): reload per REQ-021 and go to TX_BYTE.
- NACK (1): set MNACK and go to WAIT_STOP.
REQ-024 EN=0: FSM is forced to IDLE, sda is released, START is ignored; registers remain bus-accessible.
REQ-025 Simultaneous events:
- A bus RXDATA read and a new rx capture in the same cycle: the read returns the old byte, and RX_VALID stays set for the new byte.
- A TXDATA write and a tx load in the same cycle: the load takes the old value if TX_FULL, and the new write is held with TX_FULL=1.
- A W1C and a hardware set of the same bit in the same cycle: the bit ends set.

Reset
REQ-026 While resetn=0, all of the following hold immediately: mem_s_ready=0, mem_s_rdata=0, sda released, FSM=IDLE, CTRL=0, TXDATA=0, rx holding=0, STATUS=0, synchronizers/filters=1.
REQ-027 Reset mid-transfer aborts the transfer and releases sda within the same cycle; after deassertion the block ignores the bus until a fresh START.

Verification
REQ-028 CTRL=0xA1 (EN, addr 0x50); master writes 0xA0, 0x3C, STOP -> slave ACKs both bytes; RXDATA reads 0x3C; STATUS bit0 set before the read and cleared after it.
REQ-029 TXDATA=0x5A; master sends 0xA1, reads 1 byte, NACKs, STOP -> sda carries 0x5A; STATUS bit5=1, bit1=0; writing 0x20 to STATUS clears MNACK.
REQ-030 Master writes 0xA0, 0x11, 0x22 without RXDATA being read -> 0x11 is ACKed, 0x22 is NACKed; RXDATA=0x11; STATUS bit4=1.
REQ-031 Master sends address 0xB0 -> sda never driven low for the rest of the transaction; after STOP, a repeated write to 0xA0 is ACKed.
REQ-032 START, 0xA0, repeated START, 0xA1 with TX_FULL=0 -> both addresses ACKed; DIR=1; byte read is 0xFF; ERR=1.
REQ-033 resetn pulsed low during the ACK bit -> sda released in the same cycle; all STATUS bits 0; a subsequent START and 0xA0 is ACKed only after CTRL is rewritten.
